// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_pkg
// Description : Shared sequencer definitions. The segment address decoder
//               and the step-count generator both import this package so
//               they agree on state encoding and default sequence length.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Sequencer run states
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_PAUSED = 2'd2,
    SEQ_DONE   = 2'd3
  } seq_state_e;

  // Default sysclk cycles per step tick
  localparam int CLK_DIV_DEF   = 50000;
  // Default last count value of a sequence
  localparam int COUNT_MAX_DEF = 197;
  // Default count width
  localparam int CW_DEF        = 8;

  // A sequence is in progress while running or frozen by pause
  function automatic logic seq_is_busy(input logic [1:0] st);
    return (st == SEQ_RUN) || (st == SEQ_PAUSED);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divide-by-CLK_DIV counter. Advances only while
//               enabled, so a pause simply holds the current phase. tick is
//               combinational: high on the enabled cycle at the last phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int CLK_DIV = 4
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              c_PW   = ($clog2(CLK_DIV) < 1) ? 1 : $clog2(CLK_DIV);
  localparam logic [c_PW-1:0] c_LAST = c_PW'(CLK_DIV - 1);

  logic [c_PW-1:0] r_cnt;
  logic            w_at_last;

  assign w_at_last = (r_cnt == c_LAST);
  assign tick      = en & w_at_last;

  // Phase counter: clear wins, otherwise count 0..CLK_DIV-1 while enabled
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_last ? '0 : r_cnt + c_PW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_count_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_count_gen
// Description : Step-count sequencer. Divides sysclk to a slow tick and
//               advances a registered count 0..COUNT_MAX once per tick, with
//               start/stop/pause run control and one-shot or looping modes.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_count_gen
  import seq_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int COUNT_MAX = COUNT_MAX_DEF,
  parameter int CW        = CW_DEF
) (
  input  logic          sysclk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          loop_en,
  output logic [CW-1:0] count,
  output logic          pulse,
  output logic          wrap,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0]    c_IDLE      = SEQ_IDLE;
  localparam logic [1:0]    c_RUN       = SEQ_RUN;
  localparam logic [1:0]    c_PAUSED    = SEQ_PAUSED;
  localparam logic [1:0]    c_DONE      = SEQ_DONE;
  localparam logic [CW-1:0] c_COUNT_MAX = CW'(COUNT_MAX);

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          r_pulse;
  logic          r_wrap;
  logic          r_busy;
  logic          r_done;
  logic          w_pulse_next;
  logic          w_wrap_next;
  logic          w_clr;
  logic          w_active;
  logic          w_tick;

  // start or stop both restart the prescaler phase from zero
  assign w_clr = start | stop;

  // The prescaler advances on every unpaused cycle of a live sequence,
  // including the cycle that leaves PAUSED, so a pause of N cycles delays
  // the next step by exactly N cycles.
  assign w_active = ~w_clr & ~pause & ((r_state == c_RUN) | (r_state == c_PAUSED));

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .clr     (w_clr),
    .en      (w_active),
    .tick    (w_tick)
  );

  // Next-state, next-count and strobe decode; priority stop > start > pause
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_pulse_next = 1'b0;
    w_wrap_next  = 1'b0;
    if (stop) begin
      w_state_next = c_IDLE;
      w_count_next = '0;
    end else if (start) begin
      w_state_next = c_RUN;
      w_count_next = '0;
    end else if ((r_state == c_RUN) || (r_state == c_PAUSED)) begin
      if (pause) begin
        w_state_next = c_PAUSED;
      end else begin
        w_state_next = c_RUN;
        if (w_tick) begin
          if (r_count < c_COUNT_MAX) begin
            w_count_next = r_count + CW'(1);
            w_pulse_next = 1'b1;
          end else if (loop_en) begin
            w_count_next = '0;
            w_pulse_next = 1'b1;
            w_wrap_next  = 1'b1;
          end else begin
            // One-shot end: count parks at COUNT_MAX with no pulse
            w_state_next = c_DONE;
          end
        end
      end
    end
  end

  // State, count and registered status/strobe outputs
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
      r_count <= '0;
      r_pulse <= 1'b0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_pulse <= w_pulse_next;
      r_wrap  <= w_wrap_next;
      r_busy  <= seq_is_busy(w_state_next);
      r_done  <= (w_state_next == c_DONE);
    end
  end

  assign count = r_count;
  assign pulse = r_pulse;
  assign wrap  = r_wrap;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_seq_count_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_count_gen
// Description : Self-checking bench for seq_count_gen (CLK_DIV=4,
//               COUNT_MAX=5). Directed scenarios followed by random control
//               traffic, all compared every cycle against a reference model
//               that tracks elapsed running cycles and the step number.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_count_gen;

  localparam int CLK_DIV   = 4;
  localparam int COUNT_MAX = 5;
  localparam int CW        = 8;

  logic          sysclk  = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic          stop    = 1'b0;
  logic          pause   = 1'b0;
  logic          loop_en = 1'b0;
  logic [CW-1:0] count;
  logic          pulse;
  logic          wrap;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  always #5 sysclk = ~sysclk;

  seq_count_gen #(
    .CLK_DIV   (CLK_DIV),
    .COUNT_MAX (COUNT_MAX),
    .CW        (CW)
  ) dut (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .pause   (pause),
    .loop_en (loop_en),
    .count   (count),
    .pulse   (pulse),
    .wrap    (wrap),
    .busy    (busy),
    .done    (done)
  );

  // Reference model: mode, number of unpaused running cycles since the last
  // step, and the step number.
  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_DONE} mode_t;
  mode_t m_mode;
  int    m_elapsed;
  int    m_count;
  bit    m_pulse;
  bit    m_wrap;

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_elapsed = 0;
    m_count   = 0;
    m_pulse   = 1'b0;
    m_wrap    = 1'b0;
  endtask

  task automatic model_step();
    m_pulse = 1'b0;
    m_wrap  = 1'b0;
    if (stop) begin
      m_mode = M_IDLE; m_count = 0; m_elapsed = 0;
    end else if (start) begin
      m_mode = M_RUN; m_count = 0; m_elapsed = 0;
    end else if (m_mode == M_RUN || m_mode == M_PAUSED) begin
      if (pause) begin
        m_mode = M_PAUSED;
      end else begin
        m_mode    = M_RUN;
        m_elapsed = m_elapsed + 1;
        if (m_elapsed == CLK_DIV) begin
          m_elapsed = 0;
          if (m_count < COUNT_MAX) begin
            m_count = m_count + 1; m_pulse = 1'b1;
          end else if (loop_en) begin
            m_count = 0; m_pulse = 1'b1; m_wrap = 1'b1;
          end else begin
            m_mode = M_DONE;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_count));
    chk({tag, ".pulse"}, 32'(pulse), 32'(m_pulse));
    chk({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
    chk({tag, ".busy"},  32'(busy),  32'(m_mode == M_RUN || m_mode == M_PAUSED));
    chk({tag, ".done"},  32'(done),  32'(m_mode == M_DONE));
  endtask

  task automatic cyc(input string tag);
    @(posedge sysclk);
    model_step();
    cyc_no++;
    #1;
    compare_all(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) cyc(tag);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int pulses;
    int first_wrap;
    int second_wrap;

    model_reset();
    #12;
    compare_all("reset");
    reset_n = 1'b1;
    run(2, "idle");

    // One-shot sequence: steps every CLK_DIV cycles, then DONE
    loop_en = 1'b0;
    start = 1'b1; cyc("start"); start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(1));
    for (int s = 1; s <= COUNT_MAX; s++) begin
      run(CLK_DIV - 1, "step_gap");
      cyc("step");
      chk("step_count", 32'(count), 32'(s));
      chk("step_pulse", 32'(pulse), 32'(1));
    end
    run(CLK_DIV - 1, "last_gap");
    cyc("oneshot_end");
    chk("oneshot_done",  32'(done),  32'(1));
    chk("oneshot_busy",  32'(busy),  32'(0));
    chk("oneshot_count", 32'(count), 32'(COUNT_MAX));
    pulses = 0;
    repeat (20) begin
      cyc("done_hold");
      if (pulse === 1'b1) pulses++;
    end
    chk("done_no_pulse", 32'(pulses), 32'(0));

    // Looping sequence: wrap recurs every (COUNT_MAX+1)*CLK_DIV cycles
    loop_en = 1'b1;
    start = 1'b1; cyc("loop_start"); start = 1'b0;
    first_wrap  = -1;
    second_wrap = -1;
    for (int i = 0; i < 60; i++) begin
      cyc("loop");
      if (wrap === 1'b1) begin
        if (first_wrap < 0) first_wrap = cyc_no;
        else if (second_wrap < 0) second_wrap = cyc_no;
      end
    end
    chk("wrap_period", 32'(second_wrap - first_wrap), 32'((COUNT_MAX + 1) * CLK_DIV));

    // Pause two cycles after a step for ten cycles
    start = 1'b1; cyc("pause_start"); start = 1'b0;
    run(CLK_DIV, "pre_step");
    run(2, "post_step");
    pause = 1'b1;
    run(10, "paused");
    chk("paused_count", 32'(count), 32'(1));
    chk("paused_busy",  32'(busy),  32'(1));
    pause = 1'b0;
    cyc("resume1");
    chk("resume1_count", 32'(count), 32'(1));
    cyc("resume2");
    chk("resume2_count", 32'(count), 32'(2));
    chk("resume2_pulse", 32'(pulse), 32'(1));

    // start and stop together: stop wins
    start = 1'b1; cyc("ss_start"); start = 1'b0;
    run(3 * CLK_DIV, "ss_run");
    chk("ss_count3", 32'(count), 32'(3));
    start = 1'b1; stop = 1'b1; cyc("start_stop");
    chk("ss_idle_count", 32'(count), 32'(0));
    chk("ss_idle_busy",  32'(busy),  32'(0));
    stop = 1'b0; pause = 1'b1;
    cyc("start_pause");
    chk("sp_busy", 32'(busy), 32'(1));
    start = 1'b0;
    run(CLK_DIV + 2, "held_paused");
    pause = 1'b0;
    run(CLK_DIV + 1, "unpaused");

    // Asynchronous reset between clock edges at count=4
    start = 1'b1; cyc("ar_start"); start = 1'b0;
    run(4 * CLK_DIV, "ar_run");
    chk("ar_count4", 32'(count), 32'(4));
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_reset");
    @(posedge sysclk);
    #1;
    compare_all("reset_held");
    reset_n = 1'b1;
    run(6, "post_reset_idle");

    // Random control traffic
    for (int i = 0; i < 1500; i++) begin
      stop  = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 59) == 0);
      pause = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 29) == 0) loop_en = ~loop_en;
      cyc("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
